// File: rtl/stf_preamble_inserter_pkg.sv
// Shared definitions for the STF preamble inserter: settings-bus register
// offsets, CTRL bit positions, FSM state encodings and an address helper.
package stf_preamble_inserter_pkg;

  localparam int SR_CTRL     = 0;
  localparam int SR_PAT_DATA = 1;
  localparam int SR_PAT_PTR  = 2;

  localparam int CTRL_EN_BIT   = 4;
  localparam int CTRL_REPS_MSB = 3;
  localparam int CTRL_REPS_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2
  } state_e;

  function automatic logic [7:0] sr_addr(input int base, input int offset);
    return 8'(base + offset);
  endfunction

endpackage

// File: rtl/stf_preamble_inserter_pattern_ram.sv
// Short-symbol pattern store: 2^ADDR_W x WIDTH registers, written from the
// settings bus through an auto-incrementing write pointer, read asynchronously.
// Ports:
//   clk, aresetn               clock, synchronous active-low reset
//   set_stb/set_addr/set_data  settings bus (PAT_DATA and PAT_PTR decoded here)
//   rd_addr / rd_data          asynchronous read port
module stf_preamble_inserter_pattern_ram
  import stf_preamble_inserter_pkg::*;
#(
  parameter int BASE   = 0,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wptr_q <= '0;
    end else if (set_stb) begin
      if (set_addr == sr_addr(BASE, SR_PAT_DATA)) begin
        mem_q[wptr_q] <= set_data[WIDTH-1:0];
        wptr_q        <= wptr_q + ADDR_W'(1);
      end else if (set_addr == sr_addr(BASE, SR_PAT_PTR)) begin
        wptr_q <= set_data[ADDR_W-1:0];
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/stf_preamble_inserter.sv
// Prepends a programmable repeated short training sequence to every
// AXI-stream packet of IQ samples ({I[31:16],Q[15:0]}).
// Ports:
//   clk, aresetn, clear        clock, sync active-low reset, sync soft clear
//   set_stb/set_addr/set_data  settings bus (CTRL decoded here)
//   i_t*                       payload stream in
//   o_t*                       preamble + payload stream out
//
// state       | meaning
// ST_IDLE     | waiting for first sample; latches effective repetition count
// ST_PREAMBLE | emitting pattern[idx] for eff_reps symbols
// ST_PAYLOAD  | combinational pass-through until i_tlast transfers
module stf_preamble_inserter
  import stf_preamble_inserter_pkg::*;
#(
  parameter int BASE         = 0,
  parameter int WIDTH        = 32,
  parameter int SYM_LEN_LOG2 = 4,
  parameter int DEF_REPS     = 10
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam logic [SYM_LEN_LOG2-1:0] IDX_MAX = '1;

  state_e                   state_q, state_d;
  logic [SYM_LEN_LOG2-1:0]  idx_q, idx_d;
  logic [CTRL_REPS_W-1:0]   rep_q, rep_d;
  logic [CTRL_REPS_W-1:0]   eff_reps_q, eff_reps_d;
  logic                     enable_q;
  logic [CTRL_REPS_W-1:0]   reps_q;
  logic [CTRL_REPS_W-1:0]   eff_sel;
  logic [WIDTH-1:0]         pat_rd;
  logic                     unused_set_data;

  assign unused_set_data = ^set_data[31:CTRL_EN_BIT+1];

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      enable_q <= 1'b1;
      reps_q   <= CTRL_REPS_W'(DEF_REPS);
    end else if (set_stb && set_addr == sr_addr(BASE, SR_CTRL)) begin
      enable_q <= set_data[CTRL_EN_BIT];
      reps_q   <= set_data[CTRL_REPS_MSB:0];
    end
  end

  stf_preamble_inserter_pattern_ram #(
    .BASE   (BASE),
    .WIDTH  (WIDTH),
    .ADDR_W (SYM_LEN_LOG2)
  ) u_pattern_ram (
    .clk      (clk),
    .aresetn  (aresetn),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .rd_addr  (idx_q),
    .rd_data  (pat_rd)
  );

  // Disabled insertion behaves exactly like a zero repetition count.
  assign eff_sel = enable_q ? reps_q : '0;

  always_ff @(posedge clk) begin
    if (!aresetn || clear) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rep_q      <= '0;
      eff_reps_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      eff_reps_q <= eff_reps_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    eff_reps_d = eff_reps_q;
    o_tdata    = '0;
    o_tlast    = 1'b0;
    o_tvalid   = 1'b0;
    i_tready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Decision cycle only; the waiting sample is left on the input.
        if (i_tvalid) begin
          eff_reps_d = eff_sel;
          idx_d      = '0;
          rep_d      = '0;
          state_d    = (eff_sel != '0) ? ST_PREAMBLE : ST_PAYLOAD;
        end
      end
      ST_PREAMBLE: begin
        o_tdata  = pat_rd;
        o_tvalid = 1'b1;
        if (o_tready) begin
          idx_d = idx_q + SYM_LEN_LOG2'(1);
          if (idx_q == IDX_MAX) begin
            rep_d = rep_q + CTRL_REPS_W'(1);
            if (rep_q == eff_reps_q - CTRL_REPS_W'(1)) state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        o_tdata  = i_tdata;
        o_tlast  = i_tlast;
        o_tvalid = i_tvalid;
        i_tready = o_tready;
        if (i_tvalid && o_tready && i_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stf_preamble_inserter.sv
module tb_stf_preamble_inserter;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  always #5 clk = ~clk;

  stf_preamble_inserter #(
    .BASE         (0),
    .WIDTH        (32),
    .SYM_LEN_LOG2 (4),
    .DEF_REPS     (10)
  ) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .clear    (clear),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
  );

  int          total = 0;
  int          bad   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] src_q[$];
  logic [31:0] pat_m [16];
  logic [3:0]  wptr_m;
  logic [3:0]  reps_m;
  logic        en_m;
  logic        rand_rdy     = 1'b0;
  logic        passthru_chk = 1'b0;
  logic        stall_pend   = 1'b0;
  logic        after_last   = 1'b0;
  logic [31:0] stall_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) pat_m[k] = '0;
    wptr_m = '0;
    reps_m = 4'd10;
    en_m   = 1'b1;
  endtask

  task automatic drive();
    i_tvalid = (src_q.size() != 0);
    if (i_tvalid) {i_tlast, i_tdata} = src_q[0];
    else begin
      i_tlast = 1'b0;
      i_tdata = '0;
    end
    o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: observe at the falling edge, then drive just after the rising edge.
  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    if (stall_pend) chk("stall_hold", {31'b0, o_tvalid, o_tdata}, {31'b0, 1'b1, stall_data});
    if (after_last) chk("gap_cycle_valid", 64'(o_tvalid), 64'd0);
    if (passthru_chk && o_tvalid) begin
      chk("passthru_ready", 64'(i_tready), 64'(o_tready));
      chk("passthru_data", {31'b0, o_tlast, o_tdata}, {31'b0, i_tlast, i_tdata});
    end
    after_last = 1'b0;
    if (o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_beat observed=%h expected=none", {o_tlast, o_tdata});
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", 64'({o_tlast, o_tdata}), 64'(e));
        after_last = o_tlast;
      end
    end
    stall_pend = o_tvalid && !o_tready;
    stall_data = o_tdata;
    if (i_tvalid && i_tready) void'(src_q.pop_front());
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic set_wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    step();
    set_stb  = 1'b0;
    case (a)
      8'd0: begin en_m = d[4]; reps_m = d[3:0]; end
      8'd1: begin pat_m[wptr_m] = d; wptr_m = wptr_m + 4'd1; end
      8'd2: wptr_m = d[3:0];
      default: ;
    endcase
  endtask

  task automatic push_pkt(input int n);
    int          eff;
    logic [31:0] d;
    logic        l;
    eff = en_m ? int'(reps_m) : 0;
    for (int r = 0; r < eff * 16; r++) exp_q.push_back({1'b0, pat_m[r % 16]});
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      l = (i == n - 1);
      src_q.push_back({l, d});
      exp_q.push_back({l, d});
    end
  endtask

  task automatic run_out(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", 64'(exp_q.size() + src_q.size()), 64'd0);
  endtask

  initial begin
    logic [15:0] kk;
    int          n;
    aresetn  = 1'b0;
    clear    = 1'b0;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_o_tlast", 64'(o_tlast), 64'd0);
    chk("rst_o_tdata", 64'(o_tdata), 64'd0);
    chk("rst_i_tready", 64'(i_tready), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    drive();

    // Default 10 reps, pattern k -> {k,~k}, 4-sample packet.
    set_wr(8'd2, 32'd0);
    for (int k = 0; k < 16; k++) begin
      kk = 16'(k);
      set_wr(8'd1, {kk, ~kk});
    end
    push_pkt(4);
    run_out(400);

    // Insertion disabled: pure pass-through, back-to-back packets.
    set_wr(8'd0, 32'h03);
    passthru_chk = 1'b1;
    rand_rdy     = 1'b1;
    push_pkt(3);
    push_pkt(2);
    run_out(100);
    passthru_chk = 1'b0;

    // reps=2 with random output backpressure.
    set_wr(8'd0, 32'h12);
    push_pkt(5);
    run_out(400);
    rand_rdy = 1'b0;

    // CTRL rewritten during payload of A only affects B.
    push_pkt(3);
    n = 0;
    while (exp_q.size() > 3 && n < 100) begin
      step();
      n++;
    end
    chk("reach_payload_A", 64'(exp_q.size()), 64'd3);
    set_wr(8'd0, 32'h15);
    push_pkt(2);
    run_out(300);

    // Pointer wrap: entries 15 and 0 rewritten; 1-sample packet.
    set_wr(8'd2, 32'd15);
    set_wr(8'd1, 32'hCAFE_0015);
    set_wr(8'd1, 32'hBEEF_0000);
    push_pkt(1);
    run_out(200);

    // Reset in the middle of the preamble.
    push_pkt(4);
    n = 0;
    while (exp_q.size() > 34 && n < 200) begin
      step();
      n++;
    end
    chk("reach_beat_50", 64'(exp_q.size()), 64'd34);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    exp_q.delete();
    src_q.delete();
    stall_pend = 1'b0;
    after_last = 1'b0;
    model_reset();
    drive();
    @(negedge clk);
    chk("post_rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("post_rst_i_tready", 64'(i_tready), 64'd0);
    @(posedge clk);
    #1;
    drive();
    set_wr(8'd1, 32'h5A5A_A5A5);
    push_pkt(2);
    run_out(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
